// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared defaults, state encoding and clog2 helper for tdm_demux
//
// Contents:
//   DEF_CHANNELS / DEF_WIDTH : default slot count and word width
//   state_t                  : receiver state (ST_HUNT, ST_LOCKED)
//   clog2()                  : ceiling log2, usable in constant expressions
package tdm_demux_pkg;

  localparam int DEF_CHANNELS = 8;
  localparam int DEF_WIDTH    = 16;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdmux_decoder.sv
// rtl/sdmux_decoder.sv - slot index to one-hot write enable, built as a tree of 1:2 demux stages
//
// Ports:
//   sel    in  clog2(CHANNELS)  slot index to enable
//   en     in  1                accept strobe; all enables low when 0
//   onehot out CHANNELS         onehot[sel] = en, all other bits 0
//
// Level l of the tree splits every branch on sel bit (AW-1-l), so the root
// splits on the MSB and leaf index equals sel. Leaves beyond CHANNELS exist
// only when CHANNELS is not a power of two and are left unconnected.
module sdmux_decoder
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic [clog2(CHANNELS)-1:0] sel,
  input  logic                       en,
  output logic [CHANNELS-1:0]        onehot
);

  localparam int AW     = clog2(CHANNELS);
  localparam int LEAVES = 1 << AW;

  for (genvar l = 0; l < AW; l++) begin : g_lvl
    logic [(2 << l)-1:0] v;
    for (genvar n = 0; n < (1 << l); n++) begin : g_node
      logic parent;
      if (l == 0) begin : g_root
        assign parent = en;
      end else begin : g_inner
        assign parent = g_lvl[l-1].v[n];
      end
      assign v[2*n]   = parent & ~sel[AW-1-l];
      assign v[2*n+1] = parent &  sel[AW-1-l];
    end
  end

  assign onehot = g_lvl[AW-1].v[CHANNELS-1:0];

  if (LEAVES > CHANNELS) begin : g_pad
    logic unused_leaves;
    assign unused_leaves = ^g_lvl[AW-1].v[LEAVES-1:CHANNELS];
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demultiplexer: steers serial words into registered per-channel slots
//
// Ports:
//   clk        in  1                 system clock, rising edge
//   rst_n      in  1                 asynchronous active-low reset
//   in_valid   in  1                 qualifies in_data / frame_sync
//   in_data    in  WIDTH             incoming word
//   frame_sync in  1                 word is slot 0 of a frame
//   out_data   out CHANNELS*WIDTH    slot k at [k*WIDTH +: WIDTH]
//   ch_valid   out CHANNELS          one-hot pulse, slot k updated this cycle
//   frame_done out 1                 pulse, last slot written this cycle
//   sync_err   out 1                 pulse, marker arrived at nonzero slot
//   locked     out 1                 receiver is frame-aligned
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      sync_err,
  output logic                      locked
);

  localparam int            CW   = clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  state_t              state, next_state;
  logic [CW-1:0]       cnt, next_cnt;
  logic [CW-1:0]       wr_slot;
  logic                accept;
  logic                err;
  logic                done;
  logic [CHANNELS-1:0] we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      cnt        <= '0;
      out_data   <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      ch_valid   <= we;
      frame_done <= done;
      sync_err   <= err;
      for (int k = 0; k < CHANNELS; k++) begin
        if (we[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    wr_slot    = cnt;
    accept     = 1'b0;
    err        = 1'b0;
    if (in_valid) begin
      unique case (state)
        ST_HUNT: begin
          // Words before the first marker have no known slot; drop them.
          if (frame_sync) begin
            accept     = 1'b1;
            wr_slot    = '0;
            next_cnt   = CW'(1);
            next_state = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (frame_sync && (cnt != '0)) begin
            // Early marker: realign on it, the truncated frame never completes.
            err      = 1'b1;
            accept   = 1'b1;
            wr_slot  = '0;
            next_cnt = CW'(1);
          end else begin
            // A missing marker at slot 0 is tolerated; only early markers are errors.
            accept   = 1'b1;
            wr_slot  = cnt;
            next_cnt = (cnt == LAST) ? '0 : cnt + CW'(1);
          end
        end
        default: begin
          next_state = ST_HUNT;
        end
      endcase
    end
  end

  assign done   = accept && (wr_slot == LAST);
  assign locked = (state == ST_LOCKED);

  sdmux_decoder #(
    .CHANNELS (CHANNELS)
  ) u_decoder (
    .sel    (wr_slot),
    .en     (accept),
    .onehot (we)
  );

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard testbench for tdm_demux with CHANNELS=4, WIDTH=16
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          frame_sync = 1'b0;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0] ch_valid;
  logic          frame_done;
  logic          sync_err;
  logic          locked;

  tdm_demux #(
    .CHANNELS (CH),
    .WIDTH    (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .frame_sync (frame_sync),
    .out_data   (out_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*W-1:0] data;
    logic [CH-1:0]   ch;
    logic            done;
    logic            err;
  } exp_t;

  exp_t            exp_q[$];
  logic [CH*W-1:0] model_slots = '0;
  int              tests = 0;
  int              fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ch == 0 means the word must be dropped with no output.
  task automatic send(input logic [W-1:0] d, input logic s, input logic [CH-1:0] ch,
                      input logic done, input logic err);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = d;
    frame_sync = s;
    if (ch != '0) begin
      for (int k = 0; k < CH; k++) begin
        if (ch[k]) model_slots[k*W +: W] = d;
      end
      exp_q.push_back('{data: model_slots, ch: ch, done: done, err: err});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid   = 1'b0;
      frame_sync = 1'b0;
      in_data    = W'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid    = 1'b0;
    frame_sync  = 1'b0;
    rst_n       = 1'b0;
    model_slots = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((ch_valid != '0) || frame_done || sync_err)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_output: got ch_valid=%b frame_done=%b sync_err=%b expected no pulse",
                 ch_valid, frame_done, sync_err);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("ch_valid", ch_valid, e.ch);
        check("frame_done", frame_done, e.done);
        check("sync_err", sync_err, e.err);
        check("locked_on_write", locked, 1'b1);
      end
    end
  end

  initial begin
    #12;
    check("reset_out_data", out_data, '0);
    check("reset_ch_valid", ch_valid, '0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_sync_err", sync_err, 1'b0);
    check("reset_locked", locked, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full first frame
    send(16'h1111, 1'b1, 4'b0001, 1'b0, 1'b0);
    send(16'h2222, 1'b0, 4'b0010, 1'b0, 1'b0);
    send(16'h3333, 1'b0, 4'b0100, 1'b0, 1'b0);
    send(16'h4444, 1'b0, 4'b1000, 1'b1, 1'b0);
    idle(2);
    check("locked_after_frame", locked, 1'b1);

    // Early marker on third word: slots 2..3 keep 0x3333/0x4444
    send(16'hA001, 1'b1, 4'b0001, 1'b0, 1'b0);
    send(16'hA002, 1'b0, 4'b0010, 1'b0, 1'b0);
    send(16'hCCCC, 1'b1, 4'b0001, 1'b0, 1'b1);
    send(16'h5555, 1'b0, 4'b0010, 1'b0, 1'b0);
    send(16'h6666, 1'b0, 4'b0100, 1'b0, 1'b0);
    send(16'h7777, 1'b0, 4'b1000, 1'b1, 1'b0);

    // Gap of 3 idle cycles between words 1 and 2
    send(16'h8001, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(3);
    send(16'h8002, 1'b0, 4'b0010, 1'b0, 1'b0);
    send(16'h8003, 1'b0, 4'b0100, 1'b0, 1'b0);
    send(16'h8004, 1'b0, 4'b1000, 1'b1, 1'b0);

    // Back-to-back frames, markers on words 0 and 4
    send(16'hB000, 1'b1, 4'b0001, 1'b0, 1'b0);
    send(16'hB001, 1'b0, 4'b0010, 1'b0, 1'b0);
    send(16'hB002, 1'b0, 4'b0100, 1'b0, 1'b0);
    send(16'hB003, 1'b0, 4'b1000, 1'b1, 1'b0);
    send(16'hB004, 1'b1, 4'b0001, 1'b0, 1'b0);
    send(16'hB005, 1'b0, 4'b0010, 1'b0, 1'b0);
    send(16'hB006, 1'b0, 4'b0100, 1'b0, 1'b0);
    send(16'hB007, 1'b0, 4'b1000, 1'b1, 1'b0);

    // Missing marker at slot 0 is accepted without error
    send(16'hC000, 1'b0, 4'b0001, 1'b0, 1'b0);
    idle(2);

    // HUNT drops unsynced word, then locks on marker
    apply_reset();
    send(16'hAAAA, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(1);
    check("hunt_not_locked", locked, 1'b0);
    send(16'hBBBB, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(1);
    check("locked_rises", locked, 1'b1);
    idle(1);

    // Asynchronous reset mid-frame
    apply_reset();
    send(16'hF001, 1'b1, 4'b0001, 1'b0, 1'b0);
    send(16'hF002, 1'b0, 4'b0010, 1'b0, 1'b0);
    idle(1);
    #2;
    rst_n = 1'b0;
    model_slots = '0;
    #1;
    check("async_out_data", out_data, '0);
    check("async_ch_valid", ch_valid, '0);
    check("async_frame_done", frame_done, 1'b0);
    check("async_sync_err", sync_err, 1'b0);
    check("async_locked", locked, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'hF003, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(2);
    check("post_reset_hunt_locked", locked, 1'b0);
    check("post_reset_hunt_data", out_data, '0);
    send(16'hF004, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(2);
    check("post_reset_relock", locked, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
